chip8_keypad_ctrl: RTL and testbench

Parametrised keypad front end for the CHIP-8 core. It does the following:
- Synchronises and debounces NUM_KEYS raw key lines.
- Presents the debounced key map (used by EX9E/EXA1).
- Queues press/release events in a small FIFO.
- Runs a blocking wait-for-key engine with FX0A press-then-release semantics.

It sits between the board-level key matrix/scanner and the CPU execute stage.

---
 rtl/chip8_keypad_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_chip8_keypad_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_keypad_ctrl.sv
// Keypad front end: two-flop synchroniser, per-key debounce, press/release event FIFO, FX0A wait engine.
// Latency: key_state follows a clean keys_raw step after DEBOUNCE_CYCLES+2 edges; an event reaches ev_valid 2 edges after that.
// Backpressure: ev_ready stalls the FIFO; events stay pending per key while it is full and coalesce (flagging overflow) on repeats.
module chip8_keypad_ctrl #(
    parameter int  NUM_KEYS        = 16,
    parameter int  DEBOUNCE_CYCLES = 4,
    parameter int  FIFO_DEPTH      = 4,
    localparam int IDX_W           = $clog2(NUM_KEYS),
    localparam int CNT_W           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys_raw,
    output logic [NUM_KEYS-1:0] key_state,
    output logic                any_key,
    output logic                ev_valid,
    input  logic                ev_ready,
    output logic [IDX_W-1:0]    ev_key,
    output logic                ev_release,
    output logic [CNT_W-1:0]    ev_count,
    output logic                overflow,
    input  logic                overflow_clr,
    input  logic                wait_start,
    input  logic                wait_cancel,
    output logic                wait_busy,
    output logic                wait_done,
    output logic [IDX_W-1:0]    wait_key
);

    localparam int        PTR_W  = $clog2(FIFO_DEPTH);
    localparam logic [7:0] DB_MAX = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [NUM_KEYS-1:0] ONE_KEY = {{(NUM_KEYS-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic             rel;
        logic [IDX_W-1:0] key;
    } ev_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_HELD
    } state_t;

    logic [NUM_KEYS-1:0] sync1_q, sync2_q;
    logic [NUM_KEYS-1:0] key_state_q, key_prev_q;
    logic [7:0]          db_cnt_q [NUM_KEYS];
    logic [NUM_KEYS-1:0] press_pend_q, rel_pend_q;
    logic                overflow_q;

    ev_t                 mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q;

    state_t              state_q;
    logic [NUM_KEYS-1:0] arm_mask_q;
    logic [IDX_W-1:0]    cap_q;
    logic                busy_q, done_q;
    logic [IDX_W-1:0]    wait_key_q;

    logic [NUM_KEYS-1:0] rise, fall;
    logic                sel_vld, sel_rel;
    logic [IDX_W-1:0]    sel_idx;
    logic                push, pop, full;
    logic [NUM_KEYS-1:0] press_clr, rel_clr;
    logic                ovf_set;
    logic [NUM_KEYS-1:0] cand;
    logic                cand_vld;
    logic [IDX_W-1:0]    cand_idx;

    // Edges of the debounced map, seen one cycle after key_state moves.
    assign rise = key_state_q & ~key_prev_q;
    assign fall = ~key_state_q & key_prev_q;

    // Two-flop synchroniser on every raw key line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= keys_raw;
            sync2_q <= sync1_q;
        end
    end

    // Per-key debounce: flip key_state after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_state_q <= '0;
            key_prev_q  <= '0;
            for (int k = 0; k < NUM_KEYS; k++) db_cnt_q[k] <= '0;
        end else begin
            key_prev_q <= key_state_q;
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (sync2_q[k] == key_state_q[k]) begin
                    db_cnt_q[k] <= '0;
                end else if (db_cnt_q[k] == DB_MAX) begin
                    key_state_q[k] <= sync2_q[k];
                    db_cnt_q[k]    <= '0;
                end else begin
                    db_cnt_q[k] <= db_cnt_q[k] + 8'd1;
                end
            end
        end
    end

    // Pick the next pending event: lowest press first, then lowest release.
    always_comb begin
        sel_idx = '0;
        sel_rel = 1'b0;
        if (|press_pend_q) begin
            for (int k = NUM_KEYS - 1; k >= 0; k--)
                if (press_pend_q[k]) sel_idx = IDX_W'(k);
        end else begin
            sel_rel = 1'b1;
            for (int k = NUM_KEYS - 1; k >= 0; k--)
                if (rel_pend_q[k]) sel_idx = IDX_W'(k);
        end
    end

    assign sel_vld   = (|press_pend_q) | (|rel_pend_q);
    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop       = ev_valid & ev_ready;
    assign push      = sel_vld & (~full | pop);
    assign press_clr = (push & ~sel_rel) ? (ONE_KEY << sel_idx) : '0;
    assign rel_clr   = (push &  sel_rel) ? (ONE_KEY << sel_idx) : '0;
    // A repeat edge on a bit not being drained this cycle is merged and lost.
    assign ovf_set   = (|(rise & press_pend_q & ~press_clr)) | (|(fall & rel_pend_q & ~rel_clr));

    // Pending event bits and the sticky overflow flag (a new set beats a clear).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            press_pend_q <= '0;
            rel_pend_q   <= '0;
            overflow_q   <= 1'b0;
        end else begin
            press_pend_q <= (press_pend_q & ~press_clr) | rise;
            rel_pend_q   <= (rel_pend_q & ~rel_clr) | fall;
            if (ovf_set)
                overflow_q <= 1'b1;
            else if (overflow_clr)
                overflow_q <= 1'b0;
        end
    end

    // Event FIFO storage and pointers; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= '{rel: sel_rel, key: sel_idx};
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)
                count_q <= count_q + CNT_W'(1);
            else if (pop && !push)
                count_q <= count_q - CNT_W'(1);
        end
    end

    // Lowest-index fresh rise among keys not held when the wait was armed.
    always_comb begin
        cand     = rise & ~arm_mask_q;
        cand_idx = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--)
            if (cand[k]) cand_idx = IDX_W'(k);
    end
    assign cand_vld = |cand;

    // FX0A wait engine: arm, capture the first new press, complete on its release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            arm_mask_q <= '0;
            cap_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wait_key_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (wait_start && !wait_cancel) begin
                        state_q    <= ST_ARMED;
                        arm_mask_q <= key_state_q;
                        busy_q     <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    arm_mask_q <= arm_mask_q & ~fall;
                    if (wait_cancel) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (cand_vld) begin
                        state_q <= ST_HELD;
                        cap_q   <= cand_idx;
                    end
                end
                ST_HELD: begin
                    if (wait_cancel) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (fall[cap_q]) begin
                        state_q    <= ST_IDLE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        wait_key_q <= cap_q;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign key_state  = key_state_q;
    assign any_key    = |key_state_q;
    assign ev_valid   = (count_q != '0);
    assign ev_key     = mem_q[rd_ptr_q].key;
    assign ev_release = mem_q[rd_ptr_q].rel;
    assign ev_count   = count_q;
    assign overflow   = overflow_q;
    assign wait_busy  = busy_q;
    assign wait_done  = done_q;
    assign wait_key   = wait_key_q;

endmodule

// File: tb/tb_chip8_keypad_ctrl.sv
// Directed bench for chip8_keypad_ctrl: debounce timing, event FIFO ordering and
// coalescing, overflow flag, and the FX0A wait engine including cancel and reset abort.
// Outputs are sampled 1 time unit after each rising edge; inputs change at that point too.
module tb_chip8_keypad_ctrl;

    localparam int NK    = 16;
    localparam int IDX_W = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [NK-1:0]    keys_raw;
    logic [NK-1:0]    key_state;
    logic             any_key;
    logic             ev_valid;
    logic             ev_ready;
    logic [IDX_W-1:0] ev_key;
    logic             ev_release;
    logic [CNT_W-1:0] ev_count;
    logic             overflow;
    logic             overflow_clr;
    logic             wait_start;
    logic             wait_cancel;
    logic             wait_busy;
    logic             wait_done;
    logic [IDX_W-1:0] wait_key;

    int n_checks = 0;
    int n_fail   = 0;

    chip8_keypad_ctrl #(
        .NUM_KEYS(NK),
        .DEBOUNCE_CYCLES(4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .keys_raw(keys_raw),
        .key_state(key_state),
        .any_key(any_key),
        .ev_valid(ev_valid),
        .ev_ready(ev_ready),
        .ev_key(ev_key),
        .ev_release(ev_release),
        .ev_count(ev_count),
        .overflow(overflow),
        .overflow_clr(overflow_clr),
        .wait_start(wait_start),
        .wait_cancel(wait_cancel),
        .wait_busy(wait_busy),
        .wait_done(wait_done),
        .wait_key(wait_key)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Check the head event, then pop it with a one-cycle ev_ready.
    task automatic pop_expect(input string tag, input int key, input logic rel);
        check({tag, "_vld"}, 64'(ev_valid), 64'd1);
        check({tag, "_key"}, 64'(ev_key), 64'(key));
        check({tag, "_rel"}, 64'(ev_release), 64'(rel));
        ev_ready = 1'b1;
        tick(1);
        ev_ready = 1'b0;
    endtask

    int done_seen;

    initial begin
        reset        = 1'b1;
        keys_raw     = '0;
        ev_ready     = 1'b0;
        overflow_clr = 1'b0;
        wait_start   = 1'b0;
        wait_cancel  = 1'b0;
        tick(3);

        // 1: reset state
        check("rst_key_state", 64'(key_state), 64'd0);
        check("rst_ev_valid", 64'(ev_valid), 64'd0);
        reset = 1'b0;
        tick(3);
        check("idle_key_state", 64'(key_state), 64'd0);
        check("idle_any_key", 64'(any_key), 64'd0);
        check("idle_ev_count", 64'(ev_count), 64'd0);
        check("idle_overflow", 64'(overflow), 64'd0);
        check("idle_busy", 64'(wait_busy), 64'd0);
        check("idle_done", 64'(wait_done), 64'd0);
        check("idle_wait_key", 64'(wait_key), 64'd0);

        // 2: 3-cycle glitch rejected, then clean step timing
        keys_raw[5] = 1'b1;
        tick(3);
        keys_raw[5] = 1'b0;
        tick(10);
        check("glitch_key_state", 64'(key_state), 64'd0);
        check("glitch_ev_valid", 64'(ev_valid), 64'd0);
        keys_raw[5] = 1'b1;
        tick(5);
        check("step_e5_state", 64'(key_state[5]), 64'd0);
        tick(1);
        check("step_e6_state", 64'(key_state[5]), 64'd1);
        check("step_any_key", 64'(any_key), 64'd1);
        tick(1);
        check("step_e7_ev_valid", 64'(ev_valid), 64'd0);
        tick(1);
        check("step_e8_ev_valid", 64'(ev_valid), 64'd1);
        check("step_ev_count", 64'(ev_count), 64'd1);
        pop_expect("t2_press5", 5, 1'b0);
        check("t2_empty", 64'(ev_count), 64'd0);
        keys_raw[5] = 1'b0;
        tick(10);
        pop_expect("t2_rel5", 5, 1'b1);
        check("t2_any_key_off", 64'(any_key), 64'd0);

        // 3: simultaneous presses, releases fill the FIFO, pend waits for room
        keys_raw[9] = 1'b1;
        keys_raw[2] = 1'b1;
        tick(12);
        check("t3_count2", 64'(ev_count), 64'd2);
        check("t3_head_key", 64'(ev_key), 64'd2);
        check("t3_head_rel", 64'(ev_release), 64'd0);
        keys_raw[9] = 1'b0;
        keys_raw[2] = 1'b0;
        tick(12);
        check("t3_count_full", 64'(ev_count), 64'd4);
        keys_raw[3] = 1'b1;
        tick(12);
        check("t3_full_held", 64'(ev_count), 64'd4);
        check("t3_key3_state", 64'(key_state[3]), 64'd1);
        check("t3_no_ovf", 64'(overflow), 64'd0);
        ev_ready = 1'b1;
        tick(1);
        ev_ready = 1'b0;
        check("t3_push_pop_full", 64'(ev_count), 64'd4);
        pop_expect("t3_press9", 9, 1'b0);
        pop_expect("t3_rel2", 2, 1'b1);
        pop_expect("t3_rel9", 9, 1'b1);
        pop_expect("t3_press3", 3, 1'b0);
        check("t3_drained", 64'(ev_count), 64'd0);
        check("t3_ovf_still0", 64'(overflow), 64'd0);

        // 4: coalescing on key 7 while full
        keys_raw[12] = 1'b1;
        keys_raw[13] = 1'b1;
        keys_raw[14] = 1'b1;
        keys_raw[3]  = 1'b0;
        tick(12);
        check("t4_full", 64'(ev_count), 64'd4);
        keys_raw[7] = 1'b1;
        tick(10);
        check("t4_ovf_after_press", 64'(overflow), 64'd0);
        keys_raw[7] = 1'b0;
        tick(10);
        keys_raw[7] = 1'b1;
        tick(10);
        check("t4_ovf_set", 64'(overflow), 64'd1);
        check("t4_still_full", 64'(ev_count), 64'd4);
        pop_expect("t4_press12", 12, 1'b0);
        pop_expect("t4_press13", 13, 1'b0);
        pop_expect("t4_press14", 14, 1'b0);
        pop_expect("t4_rel3", 3, 1'b1);
        pop_expect("t4_press7", 7, 1'b0);
        pop_expect("t4_rel7", 7, 1'b1);
        check("t4_drained", 64'(ev_count), 64'd0);
        check("t4_ovf_sticky", 64'(overflow), 64'd1);
        overflow_clr = 1'b1;
        tick(1);
        overflow_clr = 1'b0;
        check("t4_ovf_cleared", 64'(overflow), 64'd0);
        ev_ready = 1'b1;
        keys_raw = '0;
        tick(16);
        check("t4_release_drained", 64'(ev_count), 64'd0);
        check("t4_all_up", 64'(key_state), 64'd0);

        // 5: FX0A wait with a key held at start
        keys_raw[4] = 1'b1;
        tick(10);
        wait_start = 1'b1;
        tick(1);
        wait_start = 1'b0;
        check("t5_busy", 64'(wait_busy), 64'd1);
        tick(10);
        check("t5_held_ignored", 64'(wait_busy), 64'd1);
        keys_raw[4] = 1'b0;
        tick(10);
        check("t5_rel4_no_done", 64'(wait_busy), 64'd1);
        keys_raw[11] = 1'b1;
        tick(10);
        keys_raw[6] = 1'b1;
        tick(10);
        keys_raw[6] = 1'b0;
        tick(10);
        check("t5_other_ignored", 64'(wait_busy), 64'd1);
        check("t5_no_done_yet", 64'(wait_done), 64'd0);
        keys_raw[11] = 1'b0;
        tick(6);
        check("t5_e6_done", 64'(wait_done), 64'd0);
        tick(1);
        check("t5_done_pulse", 64'(wait_done), 64'd1);
        check("t5_wait_key", 64'(wait_key), 64'd11);
        check("t5_busy_off", 64'(wait_busy), 64'd0);
        tick(1);
        check("t5_done_one_cycle", 64'(wait_done), 64'd0);
        check("t5_wait_key_held", 64'(wait_key), 64'd11);
        tick(5);
        ev_ready = 1'b0;
        check("t5_fifo_empty", 64'(ev_count), 64'd0);

        // 6: cancel beats start in IDLE, cancel mid-wait, reset mid-wait
        wait_start  = 1'b1;
        wait_cancel = 1'b1;
        tick(1);
        wait_start  = 1'b0;
        wait_cancel = 1'b0;
        check("t6_cancel_wins", 64'(wait_busy), 64'd0);
        wait_start = 1'b1;
        tick(1);
        wait_start = 1'b0;
        check("t6_busy", 64'(wait_busy), 64'd1);
        keys_raw[1] = 1'b1;
        tick(10);
        wait_cancel = 1'b1;
        tick(1);
        wait_cancel = 1'b0;
        check("t6_cancel_busy", 64'(wait_busy), 64'd0);
        check("t6_cancel_done", 64'(wait_done), 64'd0);
        keys_raw[1] = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (wait_done) done_seen++;
        end
        check("t6_no_done_after_cancel", 64'(done_seen), 64'd0);
        check("t6_events_queued", 64'(ev_count), 64'd2);
        wait_start = 1'b1;
        tick(1);
        wait_start = 1'b0;
        check("t6_rearmed", 64'(wait_busy), 64'd1);
        reset = 1'b1;
        #1;
        check("t6_reset_busy", 64'(wait_busy), 64'd0);
        check("t6_reset_fifo", 64'(ev_count), 64'd0);
        tick(2);
        reset = 1'b0;
        tick(3);
        check("t6_post_busy", 64'(wait_busy), 64'd0);
        check("t6_post_ev_valid", 64'(ev_valid), 64'd0);
        check("t6_post_key_state", 64'(key_state), 64'd0);
        check("t6_post_done", 64'(wait_done), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
